// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller: instruction
// field positions, opcode and ALU-op constants, and the multdiv FSM encoding.
package pipe_pkg;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 17;
   localparam int RT_HI  = 16;
   localparam int RT_LO  = 12;
   localparam int ALU_HI = 6;
   localparam int ALU_LO = 2;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a lw in D/X whose destination is
// read by the instruction in F/D forces a one-cycle bubble.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic [31:0] fd_ir,
   input  logic [31:0] dx_ir,
   output logic        hazard
);

   logic [4:0] dx_op;
   logic [4:0] ld_rd;
   logic [4:0] fd_op;
   logic       fd_reads_rd;
   logic       unused_bits;

   assign dx_op = dx_ir[OPC_HI:OPC_LO];
   assign ld_rd = dx_ir[RD_HI:RD_LO];
   assign fd_op = fd_ir[OPC_HI:OPC_LO];

   // Stores, compare-branches and jr read their rd field as a source operand.
   assign fd_reads_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                        (fd_op == OP_BLT) || (fd_op == OP_JR);

   assign hazard = (dx_op == OP_LW) && (ld_rd != 5'd0) &&
                   ((ld_rd == fd_ir[RS_HI:RS_LO]) ||
                    (ld_rd == fd_ir[RT_HI:RT_LO]) ||
                    (fd_reads_rd && (ld_rd == fd_ir[RD_HI:RD_LO])));

   assign unused_bits = ^{fd_ir[11:0], dx_ir[21:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: latch enables, bubble selects, and the
// start/busy/done sequencing of the multi-cycle multiplier/divider.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fd_ir,
   input  logic [31:0] dx_ir,
   input  logic        branch_taken,
   input  logic        md_ready,
   output logic        pc_en,
   output logic        fd_en,
   output logic        dx_en,
   output logic        xm_en,
   output logic        mw_en,
   output logic        fd_flush,
   output logic        dx_flush,
   output logic        xm_flush,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic        pw_en,
   output logic        md_result_sel,
   output logic        md_busy,
   output logic        md_err
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MD_TIMEOUT);

   md_state_t        state;
   logic [CNT_W-1:0] md_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             err_flag;
   logic             hazard;
   logic             dx_is_mul;
   logic             dx_is_div;
   logic             timed_out;

   load_use_detect u_load_use (
      .fd_ir  (fd_ir),
      .dx_ir  (dx_ir),
      .hazard (hazard)
   );

   assign dx_is_mul = (dx_ir[OPC_HI:OPC_LO] == OP_RTYPE) && (dx_ir[ALU_HI:ALU_LO] == ALU_MUL);
   assign dx_is_div = (dx_ir[OPC_HI:OPC_LO] == OP_RTYPE) && (dx_ir[ALU_HI:ALU_LO] == ALU_DIV);

   // The counter is 0 in the first busy cycle, so the increment hits
   // MD_TIMEOUT exactly in the MD_TIMEOUT-th busy cycle.
   assign cnt_inc   = md_cnt + 1'b1;
   assign timed_out = (cnt_inc == TIMEOUT_CNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         md_cnt   <= '0;
         err_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dx_is_mul || dx_is_div) begin
                  state  <= MD_BUSY;
                  md_cnt <= '0;
               end
            end
            MD_BUSY: begin
               md_cnt <= cnt_inc;
               if (md_ready) begin
                  err_flag <= 1'b0;
                  state    <= MD_DONE;
               end else if (timed_out) begin
                  err_flag <= 1'b1;
                  state    <= MD_DONE;
               end
            end
            MD_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are combinational so the start pulse and freeze land in the
   // same cycle the mul/div sits in D/X; reset overrides them directly.
   always_comb begin
      pc_en         = 1'b1;
      fd_en         = 1'b1;
      dx_en         = 1'b1;
      xm_en         = 1'b1;
      mw_en         = 1'b1;
      fd_flush      = 1'b0;
      dx_flush      = 1'b0;
      xm_flush      = 1'b0;
      md_ctrl_mult  = 1'b0;
      md_ctrl_div   = 1'b0;
      pw_en         = 1'b0;
      md_result_sel = 1'b0;
      md_busy       = 1'b0;
      md_err        = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (dx_is_mul || dx_is_div) begin
                  md_ctrl_mult = dx_is_mul;
                  md_ctrl_div  = dx_is_div;
                  pc_en        = 1'b0;
                  fd_en        = 1'b0;
                  dx_en        = 1'b0;
                  xm_flush     = 1'b1;
               end else if (branch_taken) begin
                  fd_flush = 1'b1;
                  dx_flush = 1'b1;
               end else if (hazard) begin
                  pc_en    = 1'b0;
                  fd_en    = 1'b0;
                  dx_flush = 1'b1;
               end
            end
            MD_BUSY: begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               dx_en    = 1'b0;
               xm_flush = 1'b1;
               md_busy  = 1'b1;
               pw_en    = md_ready || timed_out;
            end
            MD_DONE: begin
               md_result_sel = 1'b1;
               md_err        = err_flag;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

   localparam int TMO = 40;

   localparam int B_PC = 13, B_FD = 12, B_DX = 11, B_XM = 10, B_MW = 9;
   localparam int B_FDF = 8, B_DXF = 7, B_XMF = 6, B_MUL = 5, B_DIV = 4;
   localparam int B_PW = 3, B_SEL = 2, B_BUSY = 1, B_ERR = 0;
   localparam logic [13:0] RST_VEC = 14'b11111_000_000000;

   logic        clk;
   logic        reset;
   logic [31:0] fd_ir;
   logic [31:0] dx_ir;
   logic        branch_taken;
   logic        md_ready;
   logic        pc_en, fd_en, dx_en, xm_en, mw_en;
   logic        fd_flush, dx_flush, xm_flush;
   logic        md_ctrl_mult, md_ctrl_div, pw_en, md_result_sel, md_busy, md_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] obs;
   logic [13:0] last_obs;

   // model state: busy cycle index (0 = not busy), done-cycle flag, error flag
   int m_busy_n = 0;
   bit m_done   = 0;
   bit m_err    = 0;

   pipe_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .fd_ir         (fd_ir),
      .dx_ir         (dx_ir),
      .branch_taken  (branch_taken),
      .md_ready      (md_ready),
      .pc_en         (pc_en),
      .fd_en         (fd_en),
      .dx_en         (dx_en),
      .xm_en         (xm_en),
      .mw_en         (mw_en),
      .fd_flush      (fd_flush),
      .dx_flush      (dx_flush),
      .xm_flush      (xm_flush),
      .md_ctrl_mult  (md_ctrl_mult),
      .md_ctrl_div   (md_ctrl_div),
      .pw_en         (pw_en),
      .md_result_sel (md_result_sel),
      .md_busy       (md_busy),
      .md_err        (md_err)
   );

   assign obs = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
                 md_ctrl_mult, md_ctrl_div, pw_en, md_result_sel, md_busy, md_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int alu);
      return 32'((op << 27) | (rd << 22) | (rs << 17) | (rt << 12) | (alu << 2));
   endfunction

   function automatic int fld(input logic [31:0] ir, input int lo);
      return int'((ir >> lo) & 32'h1f);
   endfunction

   // 0 = neither, 1 = mul, 2 = div
   function automatic int md_kind(input logic [31:0] ir);
      if (fld(ir, 27) != 0) return 0;
      if (fld(ir, 2) == 6) return 1;
      if (fld(ir, 2) == 7) return 2;
      return 0;
   endfunction

   function automatic bit lu_ref(input logic [31:0] fd, input logic [31:0] dx);
      int ld;
      int fop;
      bit uses_rd;
      ld  = fld(dx, 22);
      fop = fld(fd, 27);
      if (fld(dx, 27) != 8 || ld == 0) return 1'b0;
      uses_rd = (fop == 7) || (fop == 2) || (fop == 6) || (fop == 4);
      return (ld == fld(fd, 17)) || (ld == fld(fd, 12)) || (uses_rd && ld == fld(fd, 22));
   endfunction

   function automatic logic [13:0] predict(input logic [31:0] fd, input logic [31:0] dx,
                                           input bit br, input bit rdy);
      logic [13:0] v;
      v = RST_VEC;
      if (m_done) begin
         v[B_SEL] = 1'b1;
         v[B_ERR] = m_err;
      end else if (m_busy_n > 0) begin
         v[B_PC] = 0; v[B_FD] = 0; v[B_DX] = 0; v[B_XMF] = 1; v[B_BUSY] = 1;
         v[B_PW] = rdy || (m_busy_n == TMO);
      end else if (md_kind(dx) != 0) begin
         v[B_PC] = 0; v[B_FD] = 0; v[B_DX] = 0; v[B_XMF] = 1;
         v[B_MUL] = (md_kind(dx) == 1);
         v[B_DIV] = (md_kind(dx) == 2);
      end else if (br) begin
         v[B_FDF] = 1; v[B_DXF] = 1;
      end else if (lu_ref(fd, dx)) begin
         v[B_PC] = 0; v[B_FD] = 0; v[B_DXF] = 1;
      end
      return v;
   endfunction

   task automatic model_step(input logic [31:0] dx, input bit rdy);
      if (m_done) begin
         m_done = 0;
      end else if (m_busy_n > 0) begin
         if (rdy) begin
            m_done = 1; m_err = 0; m_busy_n = 0;
         end else if (m_busy_n == TMO) begin
            m_done = 1; m_err = 1; m_busy_n = 0;
         end else begin
            m_busy_n++;
         end
      end else if (md_kind(dx) != 0) begin
         m_busy_n = 1;
      end
   endtask

   task automatic model_reset();
      m_busy_n = 0;
      m_done   = 0;
      m_err    = 0;
   endtask

   // Called at posedge+1: drive inputs, check at negedge, advance model at posedge.
   task automatic cycle(input logic [31:0] fd, input logic [31:0] dx, input bit br,
                        input bit rdy, input string tag);
      logic [13:0] exp_v;
      fd_ir = fd; dx_ir = dx; branch_taken = br; md_ready = rdy;
      exp_v = predict(fd, dx, br, rdy);
      @(negedge clk);
      last_obs = obs;
      check_eq(tag, 32'(last_obs), 32'(exp_v));
      @(posedge clk);
      model_step(dx, rdy);
      #1;
   endtask

   task automatic run_div_timeout(input string tag);
      logic [31:0] dv;
      dv = mk(0, 3, 1, 2, 7);
      for (int k = 0; k <= 41; k++) begin
         cycle(32'h0, dv, 1'b0, 1'b0, tag);
         if (k == 0)  check_eq({tag, "_start"}, 32'(last_obs[B_DIV]), 32'd1);
         if (k == 1)  check_eq({tag, "_busy1"}, 32'(last_obs[B_BUSY]), 32'd1);
         if (k == 39) check_eq({tag, "_nopw39"}, 32'(last_obs[B_PW]), 32'd0);
         if (k == 40) check_eq({tag, "_pw40"}, 32'(last_obs[B_PW]), 32'd1);
         if (k == 41) begin
            check_eq({tag, "_err"}, 32'(last_obs[B_ERR]), 32'd1);
            check_eq({tag, "_sel"}, 32'(last_obs[B_SEL]), 32'd1);
            check_eq({tag, "_done_pc"}, 32'(last_obs[B_PC]), 32'd1);
         end
      end
      cycle(32'h0, 32'h0, 1'b0, 1'b0, tag);
      check_eq({tag, "_idle_busy"}, 32'(last_obs[B_BUSY]), 32'd0);
      check_eq({tag, "_idle_err"}, 32'(last_obs[B_ERR]), 32'd0);
   endtask

   initial begin
      logic [31:0] mul_i;
      logic [31:0] rfd;
      logic [31:0] rdx;
      int          sel;
      int          ops[7];

      ops = '{0, 2, 4, 5, 6, 7, 8};
      mul_i = mk(0, 4, 1, 2, 6);

      // reset forces outputs even with a mul in D/X
      reset = 1'b1; fd_ir = 32'h0; dx_ir = mul_i; branch_taken = 1'b1; md_ready = 1'b1;
      #3;
      check_eq("reset_outputs", 32'(obs), 32'(RST_VEC));
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // load-use
      cycle(mk(0, 1, 5, 2, 0), mk(8, 5, 3, 0, 0), 1'b0, 1'b0, "lu_stall");
      check_eq("lu_pc_en", 32'(last_obs[B_PC]), 32'd0);
      check_eq("lu_fd_en", 32'(last_obs[B_FD]), 32'd0);
      check_eq("lu_dx_flush", 32'(last_obs[B_DXF]), 32'd1);
      cycle(mk(0, 1, 5, 2, 0), 32'h0, 1'b0, 1'b0, "lu_after");
      check_eq("lu_one_bubble", 32'(last_obs[B_PC]), 32'd1);
      cycle(mk(0, 1, 0, 2, 0), mk(8, 0, 3, 0, 0), 1'b0, 1'b0, "lu_r0");
      check_eq("lu_r0_nostall", 32'(last_obs[B_PC]), 32'd1);
      cycle(mk(7, 5, 1, 0, 0), mk(8, 5, 3, 0, 0), 1'b0, 1'b0, "lu_sw_rd");
      check_eq("lu_sw_rd_stall", 32'(last_obs[B_PC]), 32'd0);

      // taken branch in IDLE
      cycle(mk(0, 1, 2, 3, 0), mk(0, 4, 5, 6, 0), 1'b1, 1'b0, "branch");
      check_eq("br_flushes", 32'({last_obs[B_FDF], last_obs[B_DXF]}), 32'd3);
      check_eq("br_enables", 32'(last_obs[13:9]), 32'h1f);

      // stray ready in IDLE
      cycle(32'h0, 32'h0, 1'b0, 1'b1, "stray_ready");
      check_eq("stray_no_pw", 32'(last_obs[B_PW]), 32'd0);
      cycle(32'h0, 32'h0, 1'b0, 1'b0, "stray_after");
      check_eq("stray_no_state", 32'({last_obs[B_BUSY], last_obs[B_SEL]}), 32'd0);

      // mul: start at k=0, ready at k=4, branch during busy ignored
      for (int k = 0; k <= 5; k++) begin
         cycle(32'h0, mul_i, (k == 2), (k == 4), "mul");
         check_eq("mul_pulse", 32'(last_obs[B_MUL]), 32'(k == 0));
         check_eq("mul_busy", 32'(last_obs[B_BUSY]), 32'(k >= 1 && k <= 4));
         check_eq("mul_pw", 32'(last_obs[B_PW]), 32'(k == 4));
         check_eq("mul_sel", 32'(last_obs[B_SEL]), 32'(k == 5));
         check_eq("mul_pc_en", 32'(last_obs[B_PC]), 32'(k == 5));
         if (k == 2) check_eq("mul_br_ignored", 32'({last_obs[B_FDF], last_obs[B_DXF]}), 32'd0);
      end
      cycle(32'h0, 32'h0, 1'b0, 1'b0, "mul_idle");

      run_div_timeout("div_tmo");

      // reset asserted in the 8th busy cycle (counter = 7)
      for (int k = 0; k <= 7; k++) cycle(32'h0, mk(0, 3, 1, 2, 7), 1'b0, 1'b0, "pre_rst");
      #2;
      reset = 1'b1;
      #1;
      check_eq("rst_async_outputs", 32'(obs), 32'(RST_VEC));
      model_reset();
      @(posedge clk); #1;
      check_eq("rst_held_outputs", 32'(obs), 32'(RST_VEC));
      reset = 1'b0;
      cycle(32'h0, 32'h0, 1'b0, 1'b1, "post_rst_idle");
      check_eq("post_rst_no_busy", 32'(last_obs[B_BUSY]), 32'd0);
      check_eq("post_rst_no_pulse", 32'({last_obs[B_MUL], last_obs[B_DIV]}), 32'd0);
      run_div_timeout("post_rst_div");

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         sel = int'($urandom_range(0, 7));
         if (sel <= 2)      rdx = mk(8, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
         else if (sel == 3) rdx = mk(0, int'($urandom_range(0, 3)), 1, 2, 6);
         else if (sel == 4) rdx = mk(0, int'($urandom_range(0, 3)), 1, 2, 7);
         else rdx = mk(ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 7)));
         rfd = mk(ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)));
         cycle(rfd, rdx, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
